gmii_tx_framer: RTL and testbench

Transmit-side GMII frame generator in the tx_clk domain, feeding the GMII inputs (txd/tx_en/tx_er) of the RGMII/GMII converter. It accepts a payload byte stream over a valid/ready/last handshake and emits a complete Ethernet frame on GMII:

- 7-byte preamble and SFD;
- payload, zero-padded to the minimum length;
- CRC32 FCS;
- inter-frame gap.

---
 rtl/gmii_tx_framer.sv | 174 +++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble/SFD, payload, zero pad, CRC32 FCS, inter-frame gap
module gmii_tx_framer #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       tx_clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  state_t      state, state_nx;
  logic [2:0]  pre_cnt, pre_cnt_nx;
  logic [10:0] byte_cnt, byte_cnt_nx;
  logic [1:0]  fcs_cnt, fcs_cnt_nx;
  logic [15:0] ifg_cnt, ifg_cnt_nx;
  logic [31:0] crc, crc_nx;
  logic [7:0]  txd_nx;
  logic        tx_en_nx, tx_er_nx, frame_done_nx, underrun_nx;

  logic [10:0] byte_cnt_inc;
  logic [11:0] cnt_plus1;
  logic        need_pad;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  // Reflected CRC32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign byte_cnt_inc = (byte_cnt == 11'd2047) ? byte_cnt : byte_cnt + 11'd1;
  assign cnt_plus1    = {1'b0, byte_cnt} + 12'd1;
  assign need_pad     = cnt_plus1 < MIN_LEN;
  assign fcs_word     = ~crc;
  assign fcs_byte     = 8'(fcs_word >> {fcs_cnt, 3'b000});
  assign busy         = (state != IDLE);

  always_ff @(posedge tx_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      pre_cnt    <= 3'd0;
      byte_cnt   <= 11'd0;
      fcs_cnt    <= 2'd0;
      ifg_cnt    <= 16'd0;
      crc        <= CRC_INIT;
      txd        <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      pre_cnt    <= pre_cnt_nx;
      byte_cnt   <= byte_cnt_nx;
      fcs_cnt    <= fcs_cnt_nx;
      ifg_cnt    <= ifg_cnt_nx;
      crc        <= crc_nx;
      txd        <= txd_nx;
      tx_en      <= tx_en_nx;
      tx_er      <= tx_er_nx;
      frame_done <= frame_done_nx;
      underrun   <= underrun_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pre_cnt_nx    = pre_cnt;
    byte_cnt_nx   = byte_cnt;
    fcs_cnt_nx    = fcs_cnt;
    ifg_cnt_nx    = ifg_cnt;
    crc_nx        = crc;
    txd_nx        = 8'h00;
    tx_en_nx      = 1'b0;
    tx_er_nx      = 1'b0;
    frame_done_nx = 1'b0;
    underrun_nx   = 1'b0;
    s_ready       = 1'b0;

    case (state)
      IDLE: begin
        if (s_valid) begin
          txd_nx      = 8'h55;
          tx_en_nx    = 1'b1;
          pre_cnt_nx  = 3'd1;
          byte_cnt_nx = 11'd0;
          fcs_cnt_nx  = 2'd0;
          ifg_cnt_nx  = 16'd0;
          state_nx    = PRE;
        end
      end
      PRE: begin
        tx_en_nx = 1'b1;
        if (pre_cnt == 3'd7) begin
          txd_nx   = 8'hD5;
          crc_nx   = CRC_INIT;
          state_nx = DATA;
        end else begin
          txd_nx     = 8'h55;
          pre_cnt_nx = pre_cnt + 3'd1;
        end
      end
      DATA: begin
        s_ready  = 1'b1;
        tx_en_nx = 1'b1;
        if (s_valid) begin
          txd_nx      = s_data;
          tx_er_nx    = s_err;
          crc_nx      = crc_byte(crc, s_data);
          byte_cnt_nx = byte_cnt_inc;
          if (s_last) begin
            state_nx = need_pad ? PAD : FCS;
          end
        end else begin
          // Source starved mid-frame: poison the frame and skip the FCS.
          tx_er_nx    = 1'b1;
          underrun_nx = 1'b1;
          ifg_cnt_nx  = 16'd0;
          state_nx    = IFG;
        end
      end
      PAD: begin
        tx_en_nx    = 1'b1;
        crc_nx      = crc_byte(crc, 8'h00);
        byte_cnt_nx = byte_cnt_inc;
        if (!need_pad) begin
          state_nx = FCS;
        end
      end
      FCS: begin
        txd_nx     = fcs_byte;
        tx_en_nx   = 1'b1;
        fcs_cnt_nx = fcs_cnt + 2'd1;
        if (fcs_cnt == 2'd3) begin
          frame_done_nx = 1'b1;
          ifg_cnt_nx    = 16'd0;
          state_nx      = IFG;
        end
      end
      IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          ifg_cnt_nx = 16'd0;
          state_nx   = IDLE;
        end else begin
          ifg_cnt_nx = ifg_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - directed bench for gmii_tx_framer
module tb_gmii_tx_framer;

  localparam int LOGN = 8192;

  logic       tx_clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_err;
  logic       sel;
  logic       v0, v1;

  logic       r0, en0, er0, busy0, fd0, ur0;
  logic [7:0] txd0;
  logic       r1, en1, er1, busy1, fd1, ur1;
  logic [7:0] txd1;

  logic       cur_ready, c_en, c_er, c_busy, c_fd, c_ur;
  logic [7:0] c_txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] lg_txd [0:LOGN-1];
  logic       lg_en  [0:LOGN-1];
  logic       lg_er  [0:LOGN-1];
  logic       lg_rdy [0:LOGN-1];
  logic       lg_busy[0:LOGN-1];
  logic       lg_fd  [0:LOGN-1];
  logic       lg_ur  [0:LOGN-1];

  logic [7:0] pay   [0:255];
  logic [7:0] exp_b [0:255];
  int         exp_len;

  always #4 tx_clk = ~tx_clk;

  assign v0 = s_valid & ~sel;
  assign v1 = s_valid & sel;

  gmii_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) dut0 (
    .tx_clk(tx_clk), .rstn(rstn), .s_data(s_data), .s_valid(v0), .s_last(s_last),
    .s_err(s_err), .s_ready(r0), .txd(txd0), .tx_en(en0), .tx_er(er0),
    .busy(busy0), .frame_done(fd0), .underrun(ur0)
  );

  gmii_tx_framer dut (
    .tx_clk(tx_clk), .rstn(rstn), .s_data(s_data), .s_valid(v1), .s_last(s_last),
    .s_err(s_err), .s_ready(r1), .txd(txd1), .tx_en(en1), .tx_er(er1),
    .busy(busy1), .frame_done(fd1), .underrun(ur1)
  );

  assign cur_ready = sel ? r1 : r0;
  assign c_txd  = sel ? txd1 : txd0;
  assign c_en   = sel ? en1 : en0;
  assign c_er   = sel ? er1 : er0;
  assign c_busy = sel ? busy1 : busy0;
  assign c_fd   = sel ? fd1 : fd0;
  assign c_ur   = sel ? ur1 : ur0;

  always @(posedge tx_clk) cyc = cyc + 1;

  always @(negedge tx_clk) begin
    if (cyc < LOGN) begin
      lg_txd[cyc]  = c_txd;
      lg_en[cyc]   = c_en;
      lg_er[cyc]   = c_er;
      lg_rdy[cyc]  = cur_ready;
      lg_busy[cyc] = c_busy;
      lg_fd[cyc]   = c_fd;
      lg_ur[cyc]   = c_ur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] fcs_ref(input int first, input int cnt);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ exp_b[first + i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_exp(input int n, input int minf);
    int tot;
    logic [31:0] f;
    tot = (n < minf) ? minf : n;
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
    exp_b[7] = 8'hD5;
    for (int i = 0; i < tot; i++) exp_b[8 + i] = (i < n) ? pay[i] : 8'h00;
    f = fcs_ref(8, tot);
    for (int j = 0; j < 4; j++) exp_b[8 + tot + j] = f[8*j +: 8];
    exp_len = 12 + tot;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge tx_clk);
    #1;
  endtask

  task automatic find_frame(input int from, output int s, output int len);
    s = -1;
    len = 0;
    for (int i = from; i < cyc && i < LOGN; i++) begin
      if (lg_en[i]) begin
        s = i;
        break;
      end
    end
    if (s >= 0) begin
      while (s + len < cyc && lg_en[s + len]) len++;
    end
  endtask

  task automatic send(input int n, input int err_idx, input int stop_after, input bit keep_valid);
    bit to;
    int guard;
    to = 1'b0;
    guard = 0;
    for (int k = 0; k < n && !to; k++) begin
      s_data  = pay[k];
      s_err   = (k == err_idx);
      s_last  = (k == n - 1) && (stop_after < 0);
      s_valid = 1'b1;
      guard = 0;
      while (!cur_ready && !to) begin
        @(posedge tx_clk);
        #1;
        guard++;
        if (guard > 300) to = 1'b1;
      end
      if (!to) begin
        @(posedge tx_clk);
        #1;
      end
      if (k == stop_after - 1) break;
    end
    if (to) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, want 1", guard);
    end
    s_last = 1'b0;
    s_err  = 1'b0;
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = 8'h00; sel = 1'b1;
    wait_cycles(3);
    checks++; if (txd1 !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h want 00", txd1); end
    checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", en1); end
    checks++; if (er1 !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b want 0", er1); end
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", r1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
    checks++; if (fd1 !== 1'b0 || ur1 !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fd=%b ur=%b want 0 0", fd1, ur1); end
    rstn = 1'b1;
    wait_cycles(3);
    checks++; if (en1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got en=%b busy=%b want 0 0", en1, busy1); end
  endtask

  task automatic test_crc_vector;
    int t0, s, len, nfd;
    logic [31:0] lit;
    lit = 32'hCBF43926;
    sel = 1'b0;
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    build_exp(9, 0);
    t0 = cyc;
    send(9, -1, -1, 1'b0);
    wait_cycles(30);
    find_frame(t0, s, len);
    if (s < 0) begin
      checks++; errors++; $display("FAIL crc_frame_found: got none want frame");
    end else begin
      checks++; if (s != t0 + 1) begin errors++; $display("FAIL crc_pre_start: got cycle %0d want %0d", s - t0, 1); end
      checks++; if (len != 21) begin errors++; $display("FAIL crc_tx_en_len: got %0d want 21", len); end
      checks++; if (lg_rdy[t0 + 7] !== 1'b0 || lg_rdy[t0 + 8] !== 1'b1) begin errors++; $display("FAIL crc_ready_timing: got c7=%b c8=%b want 0 1", lg_rdy[t0 + 7], lg_rdy[t0 + 8]); end
      for (int i = 0; i < 17; i++) begin
        checks++; if (lg_txd[s + i] !== exp_b[i]) begin errors++; $display("FAIL crc_byte%0d: got %h want %h", i, lg_txd[s + i], exp_b[i]); end
      end
      for (int j = 0; j < 4; j++) begin
        checks++; if (lg_txd[s + 17 + j] !== lit[8*j +: 8]) begin errors++; $display("FAIL crc_fcs%0d: got %h want %h", j, lg_txd[s + 17 + j], lit[8*j +: 8]); end
      end
      checks++; if (lg_fd[s + 20] !== 1'b1) begin errors++; $display("FAIL crc_frame_done: got %b want 1", lg_fd[s + 20]); end
      nfd = 0;
      for (int i = t0; i < cyc; i++) if (lg_fd[i]) nfd++;
      checks++; if (nfd != 1) begin errors++; $display("FAIL crc_frame_done_count: got %0d want 1", nfd); end
    end
  endtask

  task automatic test_pad;
    int t0, s, len, nidle;
    sel = 1'b1;
    pay[0] = 8'hAA;
    build_exp(1, 60);
    t0 = cyc;
    send(1, -1, -1, 1'b0);
    wait_cycles(100);
    find_frame(t0, s, len);
    if (s < 0) begin
      checks++; errors++; $display("FAIL pad_frame_found: got none want frame");
    end else begin
      checks++; if (len != 72) begin errors++; $display("FAIL pad_tx_en_len: got %0d want 72", len); end
      for (int i = 0; i < 72; i++) begin
        checks++; if (lg_txd[s + i] !== exp_b[i]) begin errors++; $display("FAIL pad_byte%0d: got %h want %h", i, lg_txd[s + i], exp_b[i]); end
      end
      checks++; if (lg_fd[s + 71] !== 1'b1) begin errors++; $display("FAIL pad_frame_done: got %b want 1", lg_fd[s + 71]); end
      nidle = 0;
      for (int i = s + 72; i < s + 84; i++) if (!lg_en[i]) nidle++;
      checks++; if (nidle != 12) begin errors++; $display("FAIL pad_ifg_idle: got %0d want 12", nidle); end
      checks++; if (lg_busy[s + 82] !== 1'b1 || lg_busy[s + 83] !== 1'b0) begin errors++; $display("FAIL pad_busy_end: got %b%b want 10", lg_busy[s + 82], lg_busy[s + 83]); end
    end
  endtask

  task automatic test_back_to_back;
    int t0, s1, l1, s2, l2;
    sel = 1'b1;
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 13 + 5);
    build_exp(64, 60);
    t0 = cyc;
    send(64, -1, -1, 1'b1);
    send(64, -1, -1, 1'b0);
    wait_cycles(40);
    find_frame(t0, s1, l1);
    find_frame(s1 + l1, s2, l2);
    if (s1 < 0 || s2 < 0) begin
      checks++; errors++; $display("FAIL b2b_frames_found: got s1=%0d s2=%0d want both", s1, s2);
    end else begin
      checks++; if (l1 != 76 || l2 != 76) begin errors++; $display("FAIL b2b_len: got %0d/%0d want 76/76", l1, l2); end
      checks++; if (s2 - (s1 + l1 - 1) != 13) begin errors++; $display("FAIL b2b_restart: got %0d want 13", s2 - (s1 + l1 - 1)); end
      for (int i = 0; i < 76; i++) begin
        checks++; if (lg_txd[s1 + i] !== exp_b[i]) begin errors++; $display("FAIL b2b_f1_byte%0d: got %h want %h", i, lg_txd[s1 + i], exp_b[i]); end
        checks++; if (lg_txd[s2 + i] !== exp_b[i]) begin errors++; $display("FAIL b2b_f2_byte%0d: got %h want %h", i, lg_txd[s2 + i], exp_b[i]); end
      end
      checks++; if (lg_fd[s1 + 75] !== 1'b1 || lg_fd[s2 + 75] !== 1'b1) begin errors++; $display("FAIL b2b_frame_done: got %b%b want 11", lg_fd[s1 + 75], lg_fd[s2 + 75]); end
    end
  endtask

  task automatic test_underrun;
    int t0, s, len, nfd, nur, nidle;
    sel = 1'b1;
    build_exp(64, 60);
    t0 = cyc;
    send(64, -1, 20, 1'b0);
    wait_cycles(50);
    find_frame(t0, s, len);
    if (s < 0) begin
      checks++; errors++; $display("FAIL ur_frame_found: got none want frame");
    end else begin
      checks++; if (len != 29) begin errors++; $display("FAIL ur_tx_en_len: got %0d want 29", len); end
      for (int i = 0; i < 28; i++) begin
        checks++; if (lg_txd[s + i] !== exp_b[i]) begin errors++; $display("FAIL ur_byte%0d: got %h want %h", i, lg_txd[s + i], exp_b[i]); end
      end
      checks++; if (lg_txd[s + 28] !== 8'h00 || lg_er[s + 28] !== 1'b1) begin errors++; $display("FAIL ur_err_byte: got txd=%h er=%b want 00 1", lg_txd[s + 28], lg_er[s + 28]); end
      checks++; if (lg_ur[s + 28] !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b want 1", lg_ur[s + 28]); end
      nfd = 0; nur = 0;
      for (int i = t0; i < cyc; i++) begin
        if (lg_fd[i]) nfd++;
        if (lg_ur[i]) nur++;
      end
      checks++; if (nfd != 0) begin errors++; $display("FAIL ur_no_frame_done: got %0d want 0", nfd); end
      checks++; if (nur != 1) begin errors++; $display("FAIL ur_pulse_count: got %0d want 1", nur); end
      nidle = 0;
      for (int i = s + 29; i < s + 41; i++) if (!lg_en[i]) nidle++;
      checks++; if (nidle != 12) begin errors++; $display("FAIL ur_ifg_idle: got %0d want 12", nidle); end
      checks++; if (lg_busy[s + 39] !== 1'b1 || lg_busy[s + 40] !== 1'b0) begin errors++; $display("FAIL ur_busy_end: got %b%b want 10", lg_busy[s + 39], lg_busy[s + 40]); end
    end
  endtask

  task automatic test_error_byte;
    int t0, s, len;
    sel = 1'b1;
    build_exp(64, 60);
    t0 = cyc;
    send(64, 4, -1, 1'b0);
    wait_cycles(40);
    find_frame(t0, s, len);
    if (s < 0) begin
      checks++; errors++; $display("FAIL err_frame_found: got none want frame");
    end else begin
      checks++; if (len != 76) begin errors++; $display("FAIL err_tx_en_len: got %0d want 76", len); end
      for (int i = 0; i < 76; i++) begin
        checks++; if (lg_txd[s + i] !== exp_b[i]) begin errors++; $display("FAIL err_byte%0d: got %h want %h", i, lg_txd[s + i], exp_b[i]); end
        checks++; if (lg_er[s + i] !== (i == 12)) begin errors++; $display("FAIL err_tx_er%0d: got %b want %b", i, lg_er[s + i], (i == 12)); end
      end
      checks++; if (lg_fd[s + 75] !== 1'b1) begin errors++; $display("FAIL err_frame_done: got %b want 1", lg_fd[s + 75]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int t0, s, len;
    sel = 1'b1;
    build_exp(64, 60);
    send(64, -1, 30, 1'b0);
    checks++; if (en1 !== 1'b1 || txd1 !== pay[29]) begin errors++; $display("FAIL rst_mid_active: got en=%b txd=%h want 1 %h", en1, txd1, pay[29]); end
    rstn = 1'b0;
    #1;
    checks++; if (en1 !== 1'b0 || er1 !== 1'b0 || r1 !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got en=%b er=%b rdy=%b want 0 0 0", en1, er1, r1); end
    checks++; if (busy1 !== 1'b0 || txd1 !== 8'h00) begin errors++; $display("FAIL rst_mid_state: got busy=%b txd=%h want 0 00", busy1, txd1); end
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(2);
    t0 = cyc;
    send(64, -1, -1, 1'b0);
    wait_cycles(40);
    find_frame(t0, s, len);
    if (s < 0) begin
      checks++; errors++; $display("FAIL rst_new_frame_found: got none want frame");
    end else begin
      checks++; if (s != t0 + 1 || len != 76) begin errors++; $display("FAIL rst_new_frame_shape: got start+%0d len %0d want +1 len 76", s - t0, len); end
      for (int i = 0; i < 76; i++) begin
        checks++; if (lg_txd[s + i] !== exp_b[i]) begin errors++; $display("FAIL rst_new_byte%0d: got %h want %h", i, lg_txd[s + i], exp_b[i]); end
      end
      checks++; if (lg_fd[s + 75] !== 1'b1) begin errors++; $display("FAIL rst_new_frame_done: got %b want 1", lg_fd[s + 75]); end
    end
  endtask

  initial begin
    test_reset;
    test_crc_vector;
    test_pad;
    test_back_to_back;
    test_underrun;
    test_error_byte;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
